// File: rtl/commu_m_txbuf.sv
// commu_m_txbuf
// Frame-oriented byte buffer between local report logic and the ARM-facing
// SPI slave. Bytes are written one per cycle and become visible to the reader
// only once the byte flagged wr_last has been written. A frame that does not
// fit is discarded whole. The reader pops one byte per req_rd pulse.
//
// Ports
//   clk_sys    system clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush, same effect as reset, wins over all events
//   wr_en      write strobe, one byte per cycle
//   wr_data    byte to write
//   wr_last    with wr_en: this byte closes the frame
//   wr_full    registered: no free entry (uncommitted bytes count as used)
//   req_rd     pop pulse from the SPI slave
//   req_q      head byte, IDLE_BYTE when nothing committed is available
//   frame_rdy  registered frame_cnt != 0
//   frame_cnt  committed frames not yet fully popped
//   ovf_err    sticky: a frame was dropped
//   udr_err    sticky: req_rd with no committed byte
module commu_m_txbuf #(
  parameter int          ADDR_W    = 9,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              wr_last,
  output logic              wr_full,
  input  logic              req_rd,
  output logic [7:0]        req_q,
  output logic              frame_rdy,
  output logic [ADDR_W:0]   frame_cnt,
  output logic              ovf_err,
  output logic              udr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DROP} wr_state_t;

  wr_state_t         state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cmt_ptr_q, cmt_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   frame_cnt_q, frame_cnt_d;
  logic              wr_full_q, wr_full_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic              ovf_q, ovf_d;
  logic              udr_q, udr_d;
  logic              bypass_q, bypass_d;
  logic [8:0]        byp_data_q, byp_data_d;

  // Storage: {last flag, data byte}
  logic [8:0]        mem [DEPTH];
  logic [8:0]        ram_rd_q;

  logic [ADDR_W:0]   used, avail;
  logic [8:0]        head;
  logic              pop, pop_last, space, commit, mem_we;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  always_comb begin
    used    = wr_ptr_q - rd_ptr_q;
    avail   = cmt_ptr_q - rd_ptr_q;
    // The RAM read is registered; if the head slot was written in the same
    // cycle it was addressed, the RAM output is stale and the captured write
    // data is used instead.
    head     = bypass_q ? byp_data_q : ram_rd_q;
    pop      = req_rd && (avail != '0);
    pop_last = pop && head[8];
    // A concurrent pop frees an entry, so a push at used == DEPTH still fits.
    space    = (used != DEPTH_V) || pop;
    wr_addr  = wr_ptr_q[ADDR_W-1:0];

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cmt_ptr_d   = cmt_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    udr_d       = udr_q;
    commit      = 1'b0;
    mem_we      = 1'b0;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end else if (req_rd) begin
      udr_d = 1'b1;
    end

    if (wr_en) begin
      if (state_q == ST_DROP) begin
        if (wr_last) state_d = ST_IDLE;
      end else if (space) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE;
        if (wr_last) begin
          cmt_ptr_d = wr_ptr_q + ONE;
          commit    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end else begin
        // Rewind over the partial frame; the rest of it is swallowed in DROP.
        wr_ptr_d = cmt_ptr_q;
        ovf_d    = 1'b1;
        state_d  = wr_last ? ST_IDLE : ST_DROP;
      end
    end

    frame_cnt_d = frame_cnt_q;
    case ({commit, pop_last})
      2'b10:   frame_cnt_d = frame_cnt_q + ONE;
      2'b01:   frame_cnt_d = frame_cnt_q - ONE;
      default: frame_cnt_d = frame_cnt_q;
    endcase

    frame_rdy_d = (frame_cnt_q != '0);

    if (clr) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      cmt_ptr_d   = '0;
      rd_ptr_d    = '0;
      frame_cnt_d = '0;
      frame_rdy_d = 1'b0;
      ovf_d       = 1'b0;
      udr_d       = 1'b0;
      mem_we      = 1'b0;
    end

    wr_full_d  = ((wr_ptr_d - rd_ptr_d) == DEPTH_V);
    rd_addr    = rd_ptr_d[ADDR_W-1:0];
    bypass_d   = mem_we && (wr_addr == rd_addr);
    byp_data_d = {wr_last, wr_data};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      wr_full_q   <= 1'b0;
      frame_rdy_q <= 1'b0;
      ovf_q       <= 1'b0;
      udr_q       <= 1'b0;
      bypass_q    <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      wr_full_q   <= wr_full_d;
      frame_rdy_q <= frame_rdy_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
      bypass_q    <= bypass_d;
      byp_data_q  <= byp_data_d;
    end
  end

  // RAM with registered read, addressed by the next head so the output
  // lines up with rd_ptr_q on the following cycle.
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem[wr_addr] <= {wr_last, wr_data};
    ram_rd_q <= mem[rd_addr];
  end

  // Selection between registered sources only; IDLE_BYTE whenever nothing
  // committed is waiting.
  assign req_q     = (avail == '0) ? IDLE_BYTE : head[7:0];
  assign wr_full   = wr_full_q;
  assign frame_rdy = frame_rdy_q;
  assign frame_cnt = frame_cnt_q;
  assign ovf_err   = ovf_q;
  assign udr_err   = udr_q;

endmodule

// File: tb/tb_commu_m_txbuf.sv
module tb_commu_m_txbuf;

  localparam int AW = 4;

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b0;
  logic          clr     = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_last = 1'b0;
  logic          req_rd  = 1'b0;
  logic          wr_full;
  logic [7:0]    req_q;
  logic          frame_rdy;
  logic [AW:0]   frame_cnt;
  logic          ovf_err;
  logic          udr_err;

  int checks = 0;
  int errors = 0;

  commu_m_txbuf #(.ADDR_W(AW), .IDLE_BYTE(8'hFF)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_full   (wr_full),
    .req_rd    (req_rd),
    .req_q     (req_q),
    .frame_rdy (frame_rdy),
    .frame_cnt (frame_cnt),
    .ovf_err   (ovf_err),
    .udr_err   (udr_err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       last;
    logic       rd;
    logic       c;
    logic       chk_q;
    logic [7:0] q;
    logic [4:0] cnt;
    logic       rdy;
    logic       full;
    logic       ovf;
    logic       udr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic en, input logic [7:0] d, input logic last,
                     input logic rd, input logic c, input logic chk_q,
                     input logic [7:0] q, input logic [4:0] cnt, input logic rdy,
                     input logic full, input logic ovf, input logic udr);
    vec_t v;
    v.en = en; v.d = d; v.last = last; v.rd = rd; v.c = c;
    v.chk_q = chk_q; v.q = q; v.cnt = cnt; v.rdy = rdy;
    v.full = full; v.ovf = ovf; v.udr = udr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock: inputs applied now, outputs sampled 1 ns after the edge.
  task automatic cyc(input logic en, input logic [7:0] d, input logic last,
                     input logic rd, input logic c);
    wr_en = en; wr_data = d; wr_last = last; req_rd = rd; clr = c;
    @(posedge clk_sys);
    #1;
    wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; req_rd = 1'b0; clr = 1'b0;
  endtask

  logic [7:0] exp_bytes[$];

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset req_q", req_q, 8'hFF);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset flags", {wr_full, frame_rdy, ovf_err, udr_err}, 4'b0000);
    rst_n = 1'b1;

    //  en d      last rd clr chkq q     cnt rdy full ovf udr
    add(0, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hA2, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hA3, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 8'hA1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hA2, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hA3, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'h55, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'h66, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hFF, 0, 0, 0, 0, 1);
    add(1, 8'h77, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1, 8'h55, 1, 1, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h66, 1, 1, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h77, 1, 1, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'hFF, 0, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hB1, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    add(1, 8'hC1, 0, 0, 0, 1, 8'hB1, 1, 1, 0, 0, 0);
    add(1, 8'hC2, 1, 0, 0, 1, 8'hB1, 2, 1, 0, 0, 0);
    add(1, 8'hD1, 0, 0, 0, 1, 8'hB1, 2, 1, 0, 0, 0);
    add(1, 8'hD2, 1, 1, 0, 1, 8'hC1, 2, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hC2, 2, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hD1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hD2, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].en, vq[i].d, vq[i].last, vq[i].rd, vq[i].c);
      if (vq[i].chk_q) chk($sformatf("v%0d req_q", i), req_q, vq[i].q);
      chk($sformatf("v%0d frame_cnt", i), frame_cnt, vq[i].cnt);
      chk($sformatf("v%0d rdy/full/ovf/udr", i),
          {frame_rdy, wr_full, ovf_err, udr_err},
          {vq[i].rdy, vq[i].full, vq[i].ovf, vq[i].udr});
      $display("vec %0d en=%0b d=%h last=%0b rd=%0b clr=%0b -> q=%h cnt=%0d",
               i, vq[i].en, vq[i].d, vq[i].last, vq[i].rd, vq[i].c, req_q, frame_cnt);
    end

    // Overflow: 10-byte frame committed, 8-byte frame hits full on byte 7.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'h10 + i), (i == 9), 0, 0);
      exp_bytes.push_back(8'(8'h10 + i));
    end
    chk("ovf first frame cnt", frame_cnt, 1);
    for (int j = 0; j < 8; j++) begin
      cyc(1, 8'(8'h20 + j), (j == 7), 0, 0);
      if (j == 5) chk("ovf full at 16", wr_full, 1);
      if (j == 6) chk("ovf drop flags", {ovf_err, wr_full, frame_cnt}, {1'b1, 1'b0, 5'd1});
      $display("ovf write j=%0d full=%0b ovf=%0b cnt=%0d", j, wr_full, ovf_err, frame_cnt);
    end
    chk("ovf after drop cnt", frame_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'(8'h30 + i), (i == 2), 0, 0);
      exp_bytes.push_back(8'(8'h30 + i));
    end
    chk("ovf next frame cnt", frame_cnt, 2);
    cyc(0, 8'h00, 0, 0, 0);
    for (int k = 0; k < exp_bytes.size(); k++) begin
      chk($sformatf("ovf read %0d", k), req_q, exp_bytes[k]);
      cyc(0, 8'h00, 0, 1, 0);
    end
    chk("ovf drained", {req_q, frame_cnt, ovf_err, udr_err}, {8'hFF, 5'd0, 1'b1, 1'b0});

    // Wrap: 40 single-byte frames, each pop concurrent with the next commit.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) chk($sformatf("wrap read %0d", i - 1), req_q, 8'(8'h80 + i - 1));
      cyc(1, 8'(8'h80 + i), 1, (i > 0), 0);
      chk($sformatf("wrap cnt %0d", i), frame_cnt, 1);
      cyc(0, 8'h00, 0, 0, 0);
      $display("wrap frame %0d q=%h cnt=%0d", i, req_q, frame_cnt);
    end
    chk("wrap read 39", req_q, 8'hA7);
    cyc(0, 8'h00, 0, 1, 0);
    chk("wrap drained", {req_q, frame_cnt}, {8'hFF, 5'd0});
    cyc(0, 8'h00, 0, 0, 0);
    chk("wrap errors", {ovf_err, udr_err, frame_rdy}, 3'b000);

    // clr in FILL with one frame committed.
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 0);
    chk("clr pre udr", udr_err, 1);
    cyc(1, 8'hE1, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("clr pre frame", {req_q, frame_cnt}, {8'hE1, 5'd1});
    cyc(1, 8'hF1, 0, 0, 0);
    cyc(1, 8'hF2, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    chk("clr state", {req_q, frame_cnt, udr_err, ovf_err, wr_full, frame_rdy},
        {8'hFF, 5'd0, 4'b0000});
    cyc(1, 8'h9A, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("clr new frame", {req_q, frame_cnt}, {8'h9A, 5'd1});
    cyc(0, 8'h00, 0, 1, 0);
    chk("clr new frame drained", {req_q, frame_cnt}, {8'hFF, 5'd0});
    $display("clr sequence q=%h cnt=%0d", req_q, frame_cnt);

    // Asynchronous reset between clock edges.
    cyc(1, 8'h5A, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("areset pre", {req_q, frame_cnt}, {8'h5A, 5'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("areset immediate", {req_q, frame_cnt, frame_rdy}, {8'hFF, 5'd0, 1'b0});
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    $display("async reset q=%h cnt=%0d", req_q, frame_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
